wb_lsu_master: RTL and testbench

- Wishbone master between the core's load/store unit and the tagged wb_ram slave.
- Converts one CPU memory request (byte/half/word load-store, or tag read/write) into one Wishbone classic cycle with the correct sel encoding.
- Waits for ack, then returns sign/zero-extended read data.
- Enforces the slave's post-ack recovery window: address held stable, cyc/stb low, so the slave's tag-check stage sees a valid address.
- Flags misaligned requests and bus timeouts.

---
 rtl/wb_lsu_master.sv | 219 +++++++++++++++++++++
 tb/tb_wb_lsu_master.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_lsu_master.sv
// wb_lsu_master: Wishbone classic master for the core's load/store unit.
// Turns one byte/half/word/tag request into one bus cycle, formats the read
// data at capture, and holds the address stable through a post-ack recovery
// window so the tagged slave's check stage sees a valid address.
//
// Request handshake: a request transfers on a rising edge where req_valid_i
// and req_ready_o are both high. req_ready_o is high only in IDLE, so at most
// one request is outstanding. Each transferred request produces exactly one
// single-cycle resp_valid_o pulse; resp_err_o and resp_rdata_o are meaningful
// only while resp_valid_o is high.
module wb_lsu_master #(
   parameter int WB_DATA_WIDTH   = 32,
   parameter int WB_ADDR_WIDTH   = 32,
   parameter int RECOVERY_CYCLES = 3,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [WB_DATA_WIDTH-1:0] req_wdata_i,
   input  logic [1:0]               req_size_i,
   input  logic                     req_we_i,
   input  logic                     req_signed_i,
   output logic                     resp_valid_o,
   output logic [WB_DATA_WIDTH-1:0] resp_rdata_o,
   output logic                     resp_err_o,
   output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
   output logic [WB_DATA_WIDTH-1:0] wb_data_o,
   output logic [3:0]               wb_sel_o,
   output logic                     wb_we_o,
   output logic                     wb_cyc_o,
   output logic                     wb_stb_o,
   input  logic                     wb_ack_i,
   input  logic [WB_DATA_WIDTH-1:0] wb_data_i
);

   // One counter serves both the bus wait and the recovery window, so it is
   // sized for the longer of the two.
   localparam int CNT_MAX = (TIMEOUT_CYCLES > RECOVERY_CYCLES) ? TIMEOUT_CYCLES : RECOVERY_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVERY_CYCLES - 1);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_TAG  = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      BUS     = 2'b01,
      ERR     = 2'b10,
      RECOVER = 2'b11
   } state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;

   logic [WB_ADDR_WIDTH-1:0]   addr_q;
   logic [WB_DATA_WIDTH-1:0]   wdata_q;
   logic [1:0]                 size_q;
   logic                       we_q;
   logic                       signed_q;
   logic [3:0]                 sel_q;

   logic                       resp_valid_q, resp_valid_d;
   logic                       resp_err_q, resp_err_d;
   logic [WB_DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;

   logic                       accept;
   logic                       misaligned;
   logic [3:0]                 sel_d;
   logic [WB_DATA_WIDTH-1:0]   rd_fmt;

   // Request decode: byte lane select and alignment check on the incoming request.
   always_comb begin
      sel_d      = 4'b0000;
      misaligned = 1'b0;
      case (req_size_i)
         SZ_BYTE: sel_d = 4'b0001;
         SZ_HALF: begin
            sel_d      = 4'b0011;
            misaligned = req_addr_i[0];
         end
         SZ_WORD: begin
            sel_d      = 4'b1111;
            misaligned = (req_addr_i[1:0] != 2'b00);
         end
         default: sel_d = 4'b0101;
      endcase
   end

   // Read data formatting applied to the slave's low-aligned data at capture.
   always_comb begin
      rd_fmt = wb_data_i;
      case (size_q)
         SZ_BYTE: rd_fmt = signed_q ? {{(WB_DATA_WIDTH-8){wb_data_i[7]}}, wb_data_i[7:0]}
                                    : {{(WB_DATA_WIDTH-8){1'b0}}, wb_data_i[7:0]};
         SZ_HALF: rd_fmt = signed_q ? {{(WB_DATA_WIDTH-16){wb_data_i[15]}}, wb_data_i[15:0]}
                                    : {{(WB_DATA_WIDTH-16){1'b0}}, wb_data_i[15:0]};
         SZ_WORD: rd_fmt = wb_data_i;
         SZ_TAG:  rd_fmt = {{(WB_DATA_WIDTH-4){1'b0}}, wb_data_i[3:0]};
         default: rd_fmt = wb_data_i;
      endcase
   end

   // Next-state logic, counter updates and the registered response values.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      accept       = 1'b0;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               accept = 1'b1;
               cnt_d  = '0;
               if (misaligned) begin
                  // Misaligned requests never reach the bus; the error
                  // response appears in the following ERR cycle.
                  state_d      = ERR;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d = BUS;
               end
            end
         end
         BUS: begin
            // Ack wins over the timeout when both land on the same cycle.
            if (wb_ack_i) begin
               state_d      = RECOVER;
               cnt_d        = '0;
               resp_valid_d = 1'b1;
               resp_rdata_d = we_q ? '0 : rd_fmt;
            end else if (cnt_q == TO_LAST) begin
               state_d      = RECOVER;
               cnt_d        = '0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ERR: begin
            state_d = IDLE;
         end
         RECOVER: begin
            if (cnt_q == REC_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and response registers; reset aborts any bus cycle at once.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Request capture; these registers also hold the address/sel through recovery.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= SZ_BYTE;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         sel_q    <= 4'b0000;
      end else if (accept) begin
         addr_q   <= req_addr_i;
         wdata_q  <= req_wdata_i;
         size_q   <= req_size_i;
         we_q     <= req_we_i;
         signed_q <= req_signed_i;
         sel_q    <= sel_d;
      end
   end

   // Bus and handshake outputs decoded from the current state.
   always_comb begin
      req_ready_o  = (state_q == IDLE);
      wb_cyc_o     = (state_q == BUS);
      wb_stb_o     = (state_q == BUS);
      wb_we_o      = (state_q == BUS) && we_q;
      wb_addr_o    = addr_q;
      wb_sel_o     = sel_q;
      wb_data_o    = wdata_q;
      resp_valid_o = resp_valid_q;
      resp_err_o   = resp_err_q;
      resp_rdata_o = resp_rdata_q;
   end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master with hand-computed expectations.
module tb_wb_lsu_master;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic [1:0]  req_size_i = '0;
   logic        req_we_i = 1'b0;
   logic        req_signed_i = 1'b0;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic [31:0] wb_addr_o;
   logic [31:0] wb_data_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i = 1'b0;
   logic [31:0] wb_data_i = '0;

   int n_checks = 0;
   int n_pass   = 0;

   wb_lsu_master #(
      .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .RECOVERY_CYCLES(3), .TIMEOUT_CYCLES(16)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
      .req_we_i(req_we_i), .req_signed_i(req_signed_i),
      .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
      .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_data_i(wb_data_i)
   );

   // Clock
   always #5 wb_clk_i = ~wb_clk_i;

   // Bounded wait until the master is ready for a new request.
   task automatic wait_idle(input string name);
      int n = 0;
      while (req_ready_o !== 1'b1 && n < 60) begin
         @(negedge wb_clk_i);
         n++;
      end
      n_checks++; if (req_ready_o !== 1'b1) $display("FAIL %s_idle_wait ready=%b exp=1", name, req_ready_o); else n_pass++;
   endtask

   // Present one request for one clock; returns at the negedge after the accept edge.
   task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic we, input logic sgn);
      @(negedge wb_clk_i);
      req_addr_i   = addr;
      req_wdata_i  = wdata;
      req_size_i   = size;
      req_we_i     = we;
      req_signed_i = sgn;
      req_valid_i  = 1'b1;
      @(negedge wb_clk_i);
      req_valid_i  = 1'b0;
   endtask

   // Slave acks the current cycle with the given data; returns one cycle later.
   task automatic ack_now(input logic [31:0] data);
      wb_ack_i  = 1'b1;
      wb_data_i = data;
      @(negedge wb_clk_i);
      wb_ack_i  = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge wb_clk_i);
      n_checks++; if (req_ready_o !== 1'b1) $display("FAIL rst_ready got=%b exp=1", req_ready_o); else n_pass++;
      n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, resp_valid_o, resp_err_o} !== 5'b0) $display("FAIL rst_ctrl got=%b exp=00000", {wb_cyc_o, wb_stb_o, wb_we_o, resp_valid_o, resp_err_o}); else n_pass++;
      n_checks++; if ({wb_addr_o, wb_data_o, resp_rdata_o, wb_sel_o} !== 100'b0) $display("FAIL rst_data addr=%h data=%h rdata=%h sel=%b exp=0", wb_addr_o, wb_data_o, resp_rdata_o, wb_sel_o); else n_pass++;
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      n_checks++; if (req_ready_o !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", req_ready_o); else n_pass++;
   endtask

   task automatic test_word_load();
      wait_idle("word");
      drive_req(32'h0000_0010, 32'h0, 2'b10, 1'b0, 1'b0);
      n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b110) $display("FAIL word_bus_ctrl got=%b exp=110", {wb_cyc_o, wb_stb_o, wb_we_o}); else n_pass++;
      n_checks++; if (wb_sel_o !== 4'b1111) $display("FAIL word_sel got=%b exp=1111", wb_sel_o); else n_pass++;
      n_checks++; if (wb_addr_o !== 32'h10) $display("FAIL word_addr got=%h exp=00000010", wb_addr_o); else n_pass++;
      n_checks++; if (req_ready_o !== 1'b0) $display("FAIL word_bus_ready got=%b exp=0", req_ready_o); else n_pass++;
      @(negedge wb_clk_i);
      n_checks++; if (wb_cyc_o !== 1'b1) $display("FAIL word_bus2_cyc got=%b exp=1", wb_cyc_o); else n_pass++;
      ack_now(32'hDEAD_BEEF);
      n_checks++; if ({resp_valid_o, resp_err_o} !== 2'b10) $display("FAIL word_resp got=%b exp=10", {resp_valid_o, resp_err_o}); else n_pass++;
      n_checks++; if (resp_rdata_o !== 32'hDEAD_BEEF) $display("FAIL word_rdata got=%h exp=deadbeef", resp_rdata_o); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, req_ready_o} !== 4'b0) $display("FAIL word_recover%0d_ctrl got=%b exp=0000", i, {wb_cyc_o, wb_stb_o, wb_we_o, req_ready_o}); else n_pass++;
         n_checks++; if (wb_addr_o !== 32'h10 || wb_sel_o !== 4'b1111) $display("FAIL word_recover%0d_hold addr=%h sel=%b exp=00000010/1111", i, wb_addr_o, wb_sel_o); else n_pass++;
         if (i > 0) begin
            n_checks++; if (resp_valid_o !== 1'b0) $display("FAIL word_recover%0d_single_pulse got=%b exp=0", i, resp_valid_o); else n_pass++;
         end
         @(negedge wb_clk_i);
      end
      n_checks++; if (req_ready_o !== 1'b1) $display("FAIL word_after_recover_ready got=%b exp=1", req_ready_o); else n_pass++;
   endtask

   task automatic test_sub_word_load();
      wait_idle("sbyte");
      drive_req(32'h0000_0003, 32'h0, 2'b00, 1'b0, 1'b1);
      n_checks++; if (wb_sel_o !== 4'b0001) $display("FAIL sbyte_sel got=%b exp=0001", wb_sel_o); else n_pass++;
      n_checks++; if (wb_addr_o !== 32'h3) $display("FAIL sbyte_addr got=%h exp=00000003", wb_addr_o); else n_pass++;
      ack_now(32'h0000_0080);
      n_checks++; if (resp_rdata_o !== 32'hFFFF_FF80 || resp_valid_o !== 1'b1) $display("FAIL sbyte_rdata got=%h valid=%b exp=ffffff80/1", resp_rdata_o, resp_valid_o); else n_pass++;
      wait_idle("ubyte");
      drive_req(32'h0000_0003, 32'h0, 2'b00, 1'b0, 1'b0);
      ack_now(32'h0000_0080);
      n_checks++; if (resp_rdata_o !== 32'h0000_0080 || resp_valid_o !== 1'b1) $display("FAIL ubyte_rdata got=%h valid=%b exp=00000080/1", resp_rdata_o, resp_valid_o); else n_pass++;
      wait_idle("shalf");
      drive_req(32'h0000_0002, 32'h0, 2'b01, 1'b0, 1'b1);
      n_checks++; if (wb_sel_o !== 4'b0011) $display("FAIL shalf_sel got=%b exp=0011", wb_sel_o); else n_pass++;
      ack_now(32'h0001_8001);
      n_checks++; if (resp_rdata_o !== 32'hFFFF_8001) $display("FAIL shalf_rdata got=%h exp=ffff8001", resp_rdata_o); else n_pass++;
      wait_idle("uhalf");
      drive_req(32'h0000_0002, 32'h0, 2'b01, 1'b0, 1'b0);
      ack_now(32'h0001_8001);
      n_checks++; if (resp_rdata_o !== 32'h0000_8001) $display("FAIL uhalf_rdata got=%h exp=00008001", resp_rdata_o); else n_pass++;
   endtask

   task automatic test_half_store();
      wait_idle("hstore");
      drive_req(32'h0000_0006, 32'h0000_1234, 2'b01, 1'b1, 1'b0);
      n_checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) $display("FAIL hstore_ctrl got=%b exp=111", {wb_cyc_o, wb_stb_o, wb_we_o}); else n_pass++;
      n_checks++; if (wb_sel_o !== 4'b0011) $display("FAIL hstore_sel got=%b exp=0011", wb_sel_o); else n_pass++;
      n_checks++; if (wb_data_o !== 32'h0000_1234) $display("FAIL hstore_wdata got=%h exp=00001234", wb_data_o); else n_pass++;
      ack_now(32'hFFFF_FFFF);
      n_checks++; if ({resp_valid_o, resp_err_o} !== 2'b10 || resp_rdata_o !== 32'h0) $display("FAIL hstore_resp vld_err=%b rdata=%h exp=10/00000000", {resp_valid_o, resp_err_o}, resp_rdata_o); else n_pass++;
   endtask

   task automatic test_tag();
      wait_idle("tagw");
      drive_req(32'h0000_0020, 32'h0000_0005, 2'b11, 1'b1, 1'b0);
      n_checks++; if (wb_sel_o !== 4'b0101 || wb_we_o !== 1'b1) $display("FAIL tagw_sel_we sel=%b we=%b exp=0101/1", wb_sel_o, wb_we_o); else n_pass++;
      n_checks++; if (wb_data_o !== 32'h5 || wb_addr_o !== 32'h20) $display("FAIL tagw_data_addr data=%h addr=%h exp=00000005/00000020", wb_data_o, wb_addr_o); else n_pass++;
      ack_now(32'h0);
      n_checks++; if ({resp_valid_o, resp_err_o} !== 2'b10) $display("FAIL tagw_resp got=%b exp=10", {resp_valid_o, resp_err_o}); else n_pass++;
      wait_idle("tagr");
      drive_req(32'h0000_0020, 32'h0, 2'b11, 1'b0, 1'b0);
      n_checks++; if (wb_sel_o !== 4'b0101 || wb_we_o !== 1'b0) $display("FAIL tagr_sel_we sel=%b we=%b exp=0101/0", wb_sel_o, wb_we_o); else n_pass++;
      ack_now(32'hFFFF_FFF5);
      n_checks++; if (resp_rdata_o !== 32'h0000_0005 || resp_valid_o !== 1'b1) $display("FAIL tagr_rdata got=%h valid=%b exp=00000005/1", resp_rdata_o, resp_valid_o); else n_pass++;
   endtask

   task automatic test_misaligned();
      logic [31:0] addrs [2];
      logic [1:0]  sizes [2];
      addrs[0] = 32'h0000_0002; sizes[0] = 2'b10;
      addrs[1] = 32'h0000_0001; sizes[1] = 2'b01;
      for (int k = 0; k < 2; k++) begin
         wait_idle("misal");
         drive_req(addrs[k], 32'h0, sizes[k], 1'b0, 1'b0);
         n_checks++; if ({resp_valid_o, resp_err_o, wb_cyc_o, wb_stb_o, req_ready_o} !== 5'b11000) $display("FAIL misal%0d_resp got=%b exp=11000", k, {resp_valid_o, resp_err_o, wb_cyc_o, wb_stb_o, req_ready_o}); else n_pass++;
         n_checks++; if (resp_rdata_o !== 32'h0) $display("FAIL misal%0d_rdata got=%h exp=00000000", k, resp_rdata_o); else n_pass++;
         @(negedge wb_clk_i);
         n_checks++; if ({resp_valid_o, wb_cyc_o, req_ready_o} !== 3'b001) $display("FAIL misal%0d_after got=%b exp=001", k, {resp_valid_o, wb_cyc_o, req_ready_o}); else n_pass++;
      end
      // A byte at an odd address is a normal bus access.
      wait_idle("oddbyte");
      drive_req(32'h0000_0001, 32'h0, 2'b00, 1'b0, 1'b1);
      n_checks++; if (wb_cyc_o !== 1'b1 || wb_sel_o !== 4'b0001) $display("FAIL oddbyte_bus cyc=%b sel=%b exp=1/0001", wb_cyc_o, wb_sel_o); else n_pass++;
      ack_now(32'h0000_AB7F);
      n_checks++; if (resp_rdata_o !== 32'h0000_007F || resp_err_o !== 1'b0) $display("FAIL oddbyte_resp rdata=%h err=%b exp=0000007f/0", resp_rdata_o, resp_err_o); else n_pass++;
   endtask

   task automatic test_timeout();
      int n = 0;
      wait_idle("tmo");
      drive_req(32'h0000_0040, 32'h0, 2'b10, 1'b0, 1'b0);
      while (wb_cyc_o === 1'b1 && n < 40) begin
         n++;
         @(negedge wb_clk_i);
      end
      n_checks++; if (n !== 16) $display("FAIL tmo_bus_cycles got=%0d exp=16", n); else n_pass++;
      n_checks++; if ({resp_valid_o, resp_err_o, resp_rdata_o} !== {2'b11, 32'h0}) $display("FAIL tmo_resp vld_err=%b rdata=%h exp=11/00000000", {resp_valid_o, resp_err_o}, resp_rdata_o); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if ({wb_cyc_o, req_ready_o} !== 2'b00 || wb_addr_o !== 32'h40) $display("FAIL tmo_recover%0d cyc_rdy=%b addr=%h exp=00/00000040", i, {wb_cyc_o, req_ready_o}, wb_addr_o); else n_pass++;
         @(negedge wb_clk_i);
      end
      n_checks++; if (req_ready_o !== 1'b1) $display("FAIL tmo_idle_ready got=%b exp=1", req_ready_o); else n_pass++;
      // Ack on the last allowed BUS cycle is a success.
      drive_req(32'h0000_0044, 32'h0, 2'b10, 1'b0, 1'b0);
      repeat (15) @(negedge wb_clk_i);
      n_checks++; if (wb_cyc_o !== 1'b1) $display("FAIL tmo_edge_cyc got=%b exp=1", wb_cyc_o); else n_pass++;
      ack_now(32'h1111_2222);
      n_checks++; if ({resp_valid_o, resp_err_o} !== 2'b10 || resp_rdata_o !== 32'h1111_2222) $display("FAIL tmo_edge_resp vld_err=%b rdata=%h exp=10/11112222", {resp_valid_o, resp_err_o}, resp_rdata_o); else n_pass++;
   endtask

   task automatic test_stray_ack();
      wait_idle("stray");
      wb_ack_i  = 1'b1;
      wb_data_i = 32'hCAFE_F00D;
      for (int i = 0; i < 4; i++) begin
         @(negedge wb_clk_i);
         n_checks++; if ({resp_valid_o, wb_cyc_o, req_ready_o} !== 3'b001) $display("FAIL stray%0d got=%b exp=001", i, {resp_valid_o, wb_cyc_o, req_ready_o}); else n_pass++;
      end
      wb_ack_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      int acc_idx [$];
      int rsp_idx [$];
      wait_idle("b2b");
      req_addr_i = 32'h0000_0100; req_size_i = 2'b10; req_we_i = 1'b0; req_signed_i = 1'b0;
      req_valid_i = 1'b1;
      wb_ack_i = 1'b1; wb_data_i = 32'h0BAD_F00D;
      for (int i = 0; i < 10; i++) begin
         if (req_ready_o === 1'b1) acc_idx.push_back(i);
         if (resp_valid_o === 1'b1) rsp_idx.push_back(i);
         @(negedge wb_clk_i);
      end
      req_valid_i = 1'b0;
      wb_ack_i = 1'b0;
      n_checks++; if (acc_idx.size() !== 2 || rsp_idx.size() !== 2) $display("FAIL b2b_counts acc=%0d rsp=%0d exp=2/2", acc_idx.size(), rsp_idx.size()); else n_pass++;
      if (acc_idx.size() == 2 && rsp_idx.size() == 2) begin
         n_checks++; if (acc_idx[1] !== 5) $display("FAIL b2b_accept_period got=%0d exp=5", acc_idx[1]); else n_pass++;
         n_checks++; if (rsp_idx[0] !== 2 || rsp_idx[1] !== 7) $display("FAIL b2b_resp_slots got=%0d,%0d exp=2,7", rsp_idx[0], rsp_idx[1]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_bus();
      wait_idle("rstbus");
      drive_req(32'h0000_0048, 32'h0, 2'b10, 1'b0, 1'b0);
      @(negedge wb_clk_i);
      n_checks++; if (wb_cyc_o !== 1'b1) $display("FAIL rstbus_pre_cyc got=%b exp=1", wb_cyc_o); else n_pass++;
      wb_rst_i = 1'b1;
      wb_ack_i = 1'b1;
      wb_data_i = 32'h1234_5678;
      @(negedge wb_clk_i);
      n_checks++; if ({wb_cyc_o, wb_stb_o, resp_valid_o, req_ready_o} !== 4'b0001) $display("FAIL rstbus_abort got=%b exp=0001", {wb_cyc_o, wb_stb_o, resp_valid_o, req_ready_o}); else n_pass++;
      wb_rst_i = 1'b0;
      wb_ack_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge wb_clk_i);
         n_checks++; if ({resp_valid_o, wb_cyc_o, req_ready_o} !== 3'b001) $display("FAIL rstbus_after%0d got=%b exp=001", i, {resp_valid_o, wb_cyc_o, req_ready_o}); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_sub_word_load();
      test_half_store();
      test_tag();
      test_misaligned();
      test_timeout();
      test_stray_ack();
      test_back_to_back();
      test_reset_mid_bus();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout time=%0t limit=200000", $time);
      $fatal(1, "bench time limit reached");
   end

endmodule
